// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, mux selects
// and the control-word layout used by the main FSM, its decoder and the bench.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic       SRCA_REG = 1'b0;
  localparam logic       SRCA_PC  = 1'b1;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       illegal;
  } ctrl_t;

  // States that wait on the memory handshake and therefore honour stall.
  function automatic logic can_stall(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mainfsm_dec.sv
// Moore output decode for the main FSM: state -> control word, with the
// write strobes suppressed while the state is held or in reset.
module mainfsm_dec
  import arm_mc_pkg::*;
(
  input  state_t st,
  input  logic   gate,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (st)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.next_pc    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      S_MEMADR: ctrl.alu_src_b = SRCB_IMM;
      S_MEMRD:  ctrl.adr_src   = ADR_ALUOUT;
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src = ADR_ALUOUT;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECUTER: ctrl.alu_op = 1'b1;
      S_EXECUTEI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: ctrl.reg_w = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURESULT;
        ctrl.branch     = 1'b1;
      end
      S_UNKNOWN: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase

    // Mux selects keep their state values; only architectural writes are blocked.
    if (gate) begin
      ctrl.ir_write = 1'b0;
      ctrl.next_pc  = 1'b0;
      ctrl.reg_w    = 1'b0;
      ctrl.mem_w    = 1'b0;
    end
  end

endmodule

// File: rtl/mainfsm.sv
// Main control FSM of the multicycle ARM datapath: state register,
// next-state logic and the output decoder instance.
module mainfsm
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   hold;
  ctrl_t  ctrl;

  // funct[4:1] select the ALU operation downstream, not the next state.
  logic funct_unused;
  assign funct_unused = ^funct[4:1];

  assign hold = stall & can_stall(state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    if (hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_MEM:  state_d = S_MEMADR;
            OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_UNKNOWN;
          endcase
        end
        S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state_d = S_MEMWB;
        S_EXECUTER: state_d = S_ALUWB;
        S_EXECUTEI: state_d = S_ALUWB;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  mainfsm_dec u_dec (
    .st   (state_q),
    .gate (hold | ~reset),
    .ctrl (ctrl)
  );

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign illegal   = ctrl.illegal;
  assign state     = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: stimulus queues per-cycle expected state and
// control word, a negedge monitor pops and compares.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [1:0] op;
  logic [5:0] funct;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, illegal;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  int seq    = 0;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [12:0] outs;
  } exp_t;

  exp_t q[$];

  mainfsm dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .funct(funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp,illegal}
  function automatic logic [12:0] eo(input int s, input bit g);
    logic [12:0] v;
    case (s)
      0:  v = 13'b1_0_1_10_10_1_0_0_0_0_0;
      1:  v = 13'b0_0_1_10_10_0_0_0_0_0_0;
      2:  v = 13'b0_0_0_01_00_0_0_0_0_0_0;
      3:  v = 13'b0_1_0_00_00_0_0_0_0_0_0;
      4:  v = 13'b0_0_0_00_01_0_1_0_0_0_0;
      5:  v = 13'b0_1_0_00_00_0_0_1_0_0_0;
      6:  v = 13'b0_0_0_00_00_0_0_0_0_1_0;
      7:  v = 13'b0_0_0_01_00_0_0_0_0_1_0;
      8:  v = 13'b0_0_0_00_00_0_1_0_0_0_0;
      9:  v = 13'b0_0_0_01_10_0_0_0_1_0_0;
      10: v = 13'b0_0_0_00_00_0_0_0_0_0_1;
      default: v = '0;
    endcase
    if (g) v = v & ~13'b1_0_0_00_00_1_1_1_0_0_0;
    return v;
  endfunction

  task automatic push(input int s, input bit g);
    exp_t e;
    e.id   = seq;
    e.st   = 4'(s);
    e.outs = eo(s, g);
    q.push_back(e);
    seq++;
  endtask

  // One cycle: after the edge, apply stall and queue the state expected now.
  task automatic cyc(input int s, input bit stl, input bit g);
    @(posedge clk);
    #1;
    stall = stl;
    push(s, g);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
               Branch, ALUOp, illegal};
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state[%0d]: got %0d expected %0d", e.id, state, e.st);
        end
        checks++;
        if (act !== e.outs) begin
          errors++;
          $display("FAIL ctrl[%0d] (state %0d): got %b expected %b", e.id, e.st, act, e.outs);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    op    = 2'b00;
    funct = 6'b000000;

    // Reset held for three cycles: FETCH with strobes gated.
    repeat (3) cyc(0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(0, 0);

    // LDR, no stalls
    op = 2'b01; funct = 6'b011001;
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0); cyc(4, 0, 0); cyc(0, 0, 0);

    // ADD immediate
    op = 2'b00; funct = 6'b101000;
    cyc(1, 0, 0); cyc(7, 0, 0); cyc(8, 0, 0); cyc(0, 0, 0);

    // Data-processing register form
    op = 2'b00; funct = 6'b000100;
    cyc(1, 0, 0); cyc(6, 0, 0); cyc(8, 0, 0); cyc(0, 0, 0);

    // STR stalled two cycles in MEMWR
    op = 2'b01; funct = 6'b011000;
    cyc(1, 0, 0); cyc(2, 0, 0);
    cyc(5, 1, 1); cyc(5, 1, 1); cyc(5, 0, 0);

    // Branch: FETCH stalled once, stall in DECODE/BRANCH ignored
    op = 2'b10; funct = 6'b000000;
    cyc(0, 1, 1); cyc(0, 0, 0);
    cyc(1, 1, 0); cyc(9, 1, 0); cyc(0, 0, 0);

    // LDR stalled once in MEMRD
    op = 2'b01; funct = 6'b000001;
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 1, 1); cyc(3, 0, 0); cyc(4, 0, 0); cyc(0, 0, 0);

    // Illegal op
    op = 2'b11; funct = 6'b000000;
    cyc(1, 0, 0); cyc(10, 0, 0); cyc(0, 0, 0);

    // Reset asserted mid-instruction, away from any clock edge
    op = 2'b01; funct = 6'b011001;
    cyc(1, 0, 0); cyc(2, 0, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got state %0d expected 0", state);
    end
    checks++;
    if (IRWrite !== 1'b0 || NextPC !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate: got IRWrite=%b NextPC=%b expected 0 0", IRWrite, NextPC);
    end
    cyc(0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(0, 0);
    op = 2'b00; funct = 6'b100000;
    cyc(1, 0, 0); cyc(7, 0, 0); cyc(8, 0, 0); cyc(0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 SHALL have no parameters; all encodings are fixed constants.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- stall  input  1  memory not ready; hold state.
- op  input  2  instruction op field.
- funct  input  6  instruction funct field (bit5 = I, bit0 = L/S).
- IRWrite  output  1  instruction register load.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  output  1  SrcA select: 0 = A register, 1 = PC.
- ALUSrcB  output  2  SrcB select: 00 = WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  output  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  output  1  PC register enable.
- RegW  output  1  register file write.
- MemW  output  1  data memory write.
- Branch  output  1  branch-taken qualifier.
- ALUOp  output  1  1 = ALU decoder uses funct; 0 = add.
- illegal  output  1  current state is UNKNOWN.
- state  output  4  current state, for debug.
REQ-003 Clock SHALL be the single clock clk; reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement a Moore FSM with 11 states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
REQ-005 Transitions:
- FETCH → DECODE.
- DECODE: op=01 → MEMADR; op=00 & funct[5]=0 → EXECUTER; op=00 & funct[5]=1 → EXECUTEI; op=10 → BRANCH; op=11 → UNKNOWN.
- MEMADR: funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD → MEMWB.
- MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN → FETCH.
- EXECUTER, EXECUTEI → ALUWB.
- Unused encodings 11–15 → FETCH.
REQ-006 Outputs per state. Unlisted outputs are 0.
- FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- UNKNOWN: all 0, illegal=1.
REQ-007 Outputs SHALL be a function of the state register only; op and funct affect only the next state.
REQ-008 The stall input SHALL act only in FETCH, MEMRD and MEMWR. In those states, stall=1 SHALL hold the state and force IRWrite, NextPC, MemW and RegW to 0. Mux selects SHALL keep their state values.
REQ-009 In all other states, stall SHALL be ignored.
REQ-010 Instruction latency SHALL be, with no stalls: LDR 5, STR 4, data-processing 4, branch 3, illegal 3 cycles, counted FETCH to FETCH.
REQ-011 Each write strobe SHALL be high for exactly one cycle per unstalled visit of its state.

Reset
REQ-012 reset=0 SHALL force state=FETCH asynchronously, regardless of clk.
REQ-013 During reset, outputs SHALL equal the FETCH values from REQ-006 with IRWrite=0 and NextPC=0 (strobes gated by reset).
REQ-014 Reset asserted mid-instruction SHALL abandon the instruction. The first rising edge after release SHALL perform FETCH with strobes active.

Structure
REQ-015 State encodings and mux-select constants SHALL live in the shared package arm_mc_pkg for reuse by the decoder and the bench.
REQ-016 The design SHALL use one state register plus a combinational next-state block and an output-decode block. The state register SHALL be inline, not a reused flop, because its reset polarity differs.

Verification
REQ-017 Reset: hold reset=0 for 3 cycles, then release. Required: state=0 and IRWrite=0 during reset; IRWrite=1 and NextPC=1 in the first cycle after release.
REQ-018 LDR: op=01, funct=011001. Required states 0,1,2,3,4,0; RegW=1 with ResultSrc=01 in state 4 only.
REQ-019 ADD immediate: op=00, funct=101000. Required states 0,1,7,8,0; ALUOp=1 and ALUSrcB=01 in state 7.
REQ-020 Stall: STR with stall=1 for 2 cycles in MEMWR. Required: MemW=0 for those 2 cycles, then MemW=1 for exactly 1 cycle, then FETCH.
REQ-021 Illegal: op=11. Required states 0,1,10,0; illegal=1 in state 10 only.
REQ-022 Reset mid-op: reset=0 in MEMADR. Required: state=0 immediately, without waiting for a clk edge.
